// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
//   Constants and the state encoding shared by the RSA datapath blocks
//   (Montgomery-domain converter, Montgomery multiplier, exponentiation
//   controller).
//   Contents:
//     RSA_WIDTH - default operand/modulus width in bits
//     RSA_LEN_W - default width of the modulus MSB index (n_len)
//     state_t   - the IDLE/ITER/CORR/DONE handshake encoding. This is the
//                 same start/judge/done style the converter uses.
// ---------------------------------------------------------------------------
package rsa_pkg;

    localparam int RSA_WIDTH = 2048;
    localparam int RSA_LEN_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_CORR = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mont_mul_step.sv
// ---------------------------------------------------------------------------
// mont_step
//   One radix-2 Montgomery iteration. This block is purely combinational.
//     T      = S + (a_bit ? b : 0)
//     T      = T + n        when T is odd, so that T becomes even
//     S_next = T >> 1
//   Ports:
//     i_s      [WIDTH+1:0]  running accumulator S (S < 2n)
//     i_a_bit               current multiplicand bit, LSB first
//     i_b      [WIDTH-1:0]  multiplier
//     i_n      [WIDTH-1:0]  odd modulus
//     o_s_next [WIDTH+1:0]  accumulator after this iteration
//   The intermediate T is WIDTH+2 bits wide. With S < 2n and b < n,
//   the bound is T < 4n <= 2^(WIDTH+2), so no carry is lost.
// ---------------------------------------------------------------------------
module mont_step #(
    parameter int WIDTH = 2048
) (
    input  logic [WIDTH+1:0] i_s,
    input  logic             i_a_bit,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH+1:0] o_s_next
);

    localparam int SW = WIDTH + 2;

    logic [SW-1:0] w_b_ext;
    logic [SW-1:0] w_n_ext;
    logic [SW-1:0] w_t_add;
    logic [SW-1:0] w_t_even;

    assign w_b_ext  = {2'b00, i_b};
    assign w_n_ext  = {2'b00, i_n};

    assign w_t_add  = i_s + (i_a_bit ? w_b_ext : '0);

    // Adding the odd modulus clears bit 0. This makes the shift an exact
    // division by 2 modulo n.
    assign w_t_even = w_t_add + (w_t_add[0] ? w_n_ext : '0);

    assign o_s_next = w_t_even >> 1;

endmodule

// File: rtl/mont_mul.sv
// ---------------------------------------------------------------------------
// mont_mul
//   Bit-serial radix-2 Montgomery multiplier:
//     result = a * b * R^-1 mod n,   R = 2^(n_len+1)
//   The block runs one iteration per clock and ends with a single
//   conditional subtraction. Operands are expected in the Montgomery domain.
//   Ports:
//     clk               rising-edge clock
//     rst               synchronous reset, active-low (0 = reset)
//     start             request. It is sampled only in IDLE.
//     a      [WIDTH-1:0] multiplicand, a < n
//     b      [WIDTH-1:0] multiplier,   b < n
//     n      [WIDTH-1:0] modulus, odd, n < 2^(n_len+1)
//     n_len  [LEN_W-1:0] bit index of the MSB of n
//     result [WIDTH-1:0] product. It is valid while finish = 1.
//     finish             level signal, high in DONE
//   Latency: start is sampled on edge 0. finish rises after edge n_len+3.
//   That total is n_len+1 iterations, plus one correction cycle, plus the
//   DONE entry.
// ---------------------------------------------------------------------------
module mont_mul
    import rsa_pkg::*;
#(
    parameter int WIDTH = rsa_pkg::RSA_WIDTH,
    parameter int LEN_W = rsa_pkg::RSA_LEN_W,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    input  logic [LEN_W-1:0] n_len,
    output logic [WIDTH-1:0] result,
    output logic             finish
);

    localparam int SW = WIDTH + 2;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_n;
    logic [SW-1:0]    r_s;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_finish;

    logic [SW-1:0]    w_s_next;
    logic [CNT_W-1:0] w_cnt_init;
    logic             w_s_ge_n;
    logic [WIDTH-1:0] w_s_minus_n;
    logic [WIDTH-1:0] w_corr;

    mont_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_s      (r_s),
        .i_a_bit  (r_a[0]),
        .i_b      (r_b),
        .i_n      (r_n),
        .o_s_next (w_s_next)
    );

    // The iteration count is n_len+1. CNT_W is wide enough to hold WIDTH.
    assign w_cnt_init  = CNT_W'(n_len) + CNT_W'(1);

    // The comparison uses the full WIDTH+2-bit accumulator. Only the low
    // WIDTH bits of the difference reach result. These bits are the same
    // whether the subtraction is done at WIDTH or at WIDTH+2 bits.
    assign w_s_ge_n    = (r_s >= {2'b00, r_n});
    assign w_s_minus_n = r_s[WIDTH-1:0] - r_n;
    assign w_corr      = w_s_ge_n ? w_s_minus_n : r_s[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_finish <= 1'b0;
            r_result <= '0;
            r_s      <= '0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_n      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_finish <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_n     <= n;
                        r_s     <= '0;
                        r_cnt   <= w_cnt_init;
                        r_state <= ST_ITER;
                    end
                end

                ST_ITER: begin
                    // r_a shifts right, so its bit 0 is always the current
                    // bit index (n_len+1) - cnt.
                    r_s   <= w_s_next;
                    r_a   <= r_a >> 1;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_CORR;
                    end
                end

                ST_CORR: begin
                    r_result <= w_corr;
                    r_state  <= ST_DONE;
                end

                ST_DONE: begin
                    // The first DONE edge raises finish. After that, a low
                    // start releases the block back to IDLE. Holding start
                    // high therefore never re-triggers an operation.
                    if (!r_finish) begin
                        r_finish <= 1'b1;
                    end else if (!start) begin
                        r_finish <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_finish <= 1'b0;
                end
            endcase
        end
    end

    assign result = r_result;
    assign finish = r_finish;

endmodule

// File: tb/tb_mont_mul.sv
// ---------------------------------------------------------------------------
// tb_mont_mul
//   Directed bench for mont_mul.
//     - A small instance: WIDTH=8, n=13, n_len=3, so R=16 and R^-1 mod 13 = 9.
//     - A full-width instance: WIDTH=2048, with a random odd n whose MSB is
//       at bit 2047.
//   The wide result is checked by multiplying back by R with wide
//   arithmetic.
// ---------------------------------------------------------------------------
module tb_mont_mul;

    logic         clk;
    logic         rst;
    logic         start;
    logic [7:0]   a;
    logic [7:0]   b;
    logic [7:0]   n;
    logic [2:0]   n_len;
    logic [7:0]   result;
    logic         finish;

    logic            bstart;
    logic [2047:0]   ba;
    logic [2047:0]   bb;
    logic [2047:0]   bn;
    logic [10:0]     bn_len;
    logic [2047:0]   bresult;
    logic            bfinish;

    int n_checks;
    int n_err;

    mont_mul #(
        .WIDTH (8),
        .LEN_W (3),
        .CNT_W (4)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .n      (n),
        .n_len  (n_len),
        .result (result),
        .finish (finish)
    );

    mont_mul #(
        .WIDTH (2048),
        .LEN_W (11),
        .CNT_W (12)
    ) u_dut_big (
        .clk    (clk),
        .rst    (rst),
        .start  (bstart),
        .a      (ba),
        .b      (bb),
        .n      (bn),
        .n_len  (bn_len),
        .result (bresult),
        .finish (bfinish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // This task releases any DONE state first. It then issues one request
    // and counts edges until finish is seen. The inputs are scrambled right
    // after the capture edge. If hold is set, start stays high.
    task automatic op(input logic [7:0] ai, input logic [7:0] bi, input logic [7:0] ni,
                      input logic [2:0] li, input bit hold, output int lat);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = ai; b = bi; n = ni; n_len = li; start = 1'b1;
        @(posedge clk);
        lat = -1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        a = 8'hff; b = 8'hff; n = 8'h80; n_len = 3'd7;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (finish) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                             input logic [7:0] ni, input logic [2:0] li,
                             input logic [7:0] exp_r, input int exp_lat);
        int lat;
        op(ai, bi, ni, li, 1'b0, lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, 64'(result), 64'(exp_r));
    endtask

    initial begin
        int            lat;
        logic [4095:0] ae, be, ne, lhs, rhs;

        n_checks = 0;
        n_err    = 0;
        rst = 1'b0; start = 1'b0;
        a = '0; b = '0; n = 8'd13; n_len = 3'd3;
        bstart = 1'b0; ba = '0; bb = '0; bn = '0; bn_len = 11'd2047;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_finish", 64'(finish), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        rst = 1'b1;

        // The main products use n=13, n_len=3 and R^-1 = 9.
        run_check("p5x7",   8'd5,  8'd7,  8'd13, 3'd3, 8'd3, 6);
        run_check("from5",  8'd2,  8'd1,  8'd13, 3'd3, 8'd5, 6);
        run_check("r7x3",   8'd7,  8'd3,  8'd13, 3'd3, 8'd7, 6);
        run_check("zero_a", 8'd0,  8'd12, 8'd13, 3'd3, 8'd0, 6);
        run_check("p12x12", 8'd12, 8'd12, 8'd13, 3'd3, 8'd9, 6);
        // For n=11, R=16 and R^-1 mod 11 = 9, so 3*4*9 mod 11 = 9.
        run_check("n11",    8'd3,  8'd4,  8'd11, 3'd3, 8'd9, 6);

        // With start held, the block stays in DONE and does not restart.
        op(8'd4, 8'd9, 8'd13, 3'd3, 1'b1, lat);
        check("hold_lat", 64'(lat), 64'd6);
        check("hold_res", 64'(result), 64'd12);
        repeat (5) @(posedge clk);
        #1;
        check("hold_fin_stay", 64'(finish), 64'd1);
        check("hold_res_stay", 64'(result), 64'd12);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("hold_release", 64'(finish), 64'd0);
        run_check("after_hold", 8'd3, 8'd4, 8'd13, 3'd3, 8'd4, 6);

        // Reset is applied at edge 2 of an operation.
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'd9; b = 8'd11; n = 8'd13; n_len = 3'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_finish", 64'(finish), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_idle", 64'(finish), 64'd0);
        // 6*10*9 mod 13 = 7.
        run_check("post_rst", 8'd6, 8'd10, 8'd13, 3'd3, 8'd7, 6);

        // n=1 with n_len=0 runs a single iteration.
        run_check("nlen0", 8'd0, 8'd0, 8'd1, 3'd0, 8'd0, 3);

        // An even modulus has no defined result, but the latency still holds.
        op(8'd5, 8'd3, 8'd12, 3'd3, 1'b0, lat);
        check("even_n_lat", 64'(lat), 64'd6);

        // The full-width operation. The check is result*2^2048 == a*b (mod n).
        for (int w = 0; w < 64; w++) begin
            bn[w*32 +: 32] = $urandom;
            ba[w*32 +: 32] = $urandom;
            bb[w*32 +: 32] = $urandom;
        end
        bn[2047] = 1'b1;
        bn[0]    = 1'b1;
        ba = ba % bn;
        bb = bb % bn;
        @(negedge clk);
        bstart = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bstart = 1'b0;
        lat = -1;
        for (int k = 1; k <= 2200; k++) begin
            @(posedge clk);
            #1;
            if (bfinish) begin
                lat = k;
                break;
            end
        end
        check("big_lat", 64'(lat), 64'd2050);
        ae  = {2048'b0, ba};
        be  = {2048'b0, bb};
        ne  = {2048'b0, bn};
        rhs = (ae * be) % ne;
        lhs = ({2048'b0, bresult} << 2048) % ne;
        check("big_lt_n", 64'(bresult < bn), 64'd1);
        check("big_low64", lhs[63:0], rhs[63:0]);
        check("big_congr", 64'(lhs == rhs), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mont_mul.md
Name: mont_mul

Overview:
- Bit-serial radix-2 Montgomery multiplier. Computes result = a·b·R⁻¹ mod n, where R = 2^(n_len+1).
- Sits directly downstream of the Montgomery-domain converter. It consumes operands already mapped into the Montgomery domain (x·R mod n).
- It is the core multiply used by the modular-exponentiation controller.
- One iteration per clock. A single conditional subtraction at the end.

Parameters:
- WIDTH, 2048, operand/modulus width in bits
- LEN_W, 11, width of n_len (index of the modulus MSB)
- CNT_W, 12, iteration counter width; must hold WIDTH+1

Ports:
- clk     input   1        rising-edge clock
- rst     input   1        reset, synchronous, active-low (0 = reset)
- start   input   1        request; sampled only in IDLE
- a       input   WIDTH    multiplicand, requirement a < n
- b       input   WIDTH    multiplier, requirement b < n
- n       input   WIDTH    modulus, requirement odd, n < 2^(n_len+1)
- n_len   input   LEN_W    bit index of MSB of n
- result  output  WIDTH    a·b·R⁻¹ mod n, valid while finish=1
- finish  output  1        level, high in DONE

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, finish=0, result=0.
  - Internal accumulator S=0, counter=0.
  - Reset overrides every state, including mid-iteration; no partial result is kept.
- States: IDLE, ITER, CORR, DONE (2-bit encoding).
- IDLE:
  - finish=0.
  - If start=1, register a, b and n into internal copies, set S=0, cnt=n_len+1, then go to ITER.
  - Inputs are ignored after this capture edge.
- ITER: one iteration per cycle, with bit index i = (n_len+1) − cnt, LSB first.
  - T = S + (a_reg[i] ? b_reg : 0).
  - If T is odd, T = T + n_reg.
  - S = T >> 1. cnt = cnt − 1.
  - When cnt reaches 0 after the update, go to CORR.
- CORR:
  - If S ≥ n_reg, result = S − n_reg; otherwise result = S.
  - Go to DONE.
- DONE:
  - finish=1, result held.
  - Stay in DONE while start=1.
  - When start=0, return to IDLE and drop finish to 0 on that edge.
  - result keeps its value until the next CORR.
- Latency:
  - The edge that samples start is edge 0.
  - finish goes high after edge n_len+3 (n_len+1 ITER cycles, plus 1 CORR cycle, plus the DONE entry).
  - WIDTH=2048, n_len=2047: finish after edge 2050.
- Widths:
  - S and T are WIDTH+2 bits. Invariant S < 2n, T < 4n; no overflow.
  - The subtraction in CORR uses WIDTH+2 bits; result takes the low WIDTH bits.
- Boundary conditions:
  - a=0 or b=0 gives result=0.
  - n_len=0 (n=1) gives 1 iteration and result=0.
  - start held high continuously gives exactly one operation; a new operation needs start low for ≥1 cycle.
  - Violated preconditions (n even, a≥n, b≥n) give an undefined result. Even in that case: no hang, and finish is still asserted at the same latency.

Decomposition:
- Shared package (rsa_pkg):
  - WIDTH and LEN_W constants.
  - The state encoding (IDLE/ITER/CORR/DONE), shared with the converter's start/judge/done style.
- One natural sub-module: mont_step. This is the combinational single iteration: inputs S, a_bit, b, n; output S_next.
- The FSM, counter and CORR subtractor stay in mont_mul.

Test Plan:
- All scenarios use WIDTH=8, n=13, n_len=3 (R=16, R⁻¹ mod 13 = 9) unless stated.
- a=5, b=7, start pulse → finish high after edge 6, result=3.
- a=2 (5·R mod 13), b=1 → result=5 (conversion out of the Montgomery domain). Also a=7, b=3 (R mod 13) → result=7.
- a=0, b=12 → result=0. Then a=12, b=12 → result=(144·9) mod 13 = 9.
- start held high through DONE → finish stays 1 and result stays stable, with no restart. Drop start → IDLE next edge, finish=0. Reassert start → second result correct.
- rst=0 during ITER (edge 2) → next edge state IDLE, finish=0, result=0. A new start gives a correct result with no stale S.
- WIDTH=2048, random odd n with MSB at bit 2047, random a, b < n → result matches a reference model (a·b·2⁻²⁰⁴⁸ mod n) and finish asserts after edge 2050.
